// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-code decode and EX/MEM, MEM/WB operand forwarding.
// Latency: decode inputs appear on the outputs 1 cycle later; forwarding muxes are combinational.
// Backpressure: stall_i holds every registered field; flush_i (or an invalid load) inserts a bubble.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [63:0] rs1_data_i,
  input  logic [63:0] rs2_data_i,
  input  logic [63:0] imm_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  alu_op_i,
  input  logic        alu_src_i,
  input  logic [2:0]  funct3_i,
  input  logic        instr30_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [4:0]  exmem_rd_i,
  input  logic        exmem_reg_write_i,
  input  logic [63:0] exmem_result_i,
  input  logic [4:0]  memwb_rd_i,
  input  logic        memwb_reg_write_i,
  input  logic [63:0] memwb_result_i,
  output logic [63:0] src1_o,
  output logic [63:0] src2_o,
  output logic [3:0]  ctrl_o,
  output logic        valid_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [4:0]  rd_addr_o,
  output logic [63:0] store_data_o
);

  logic        valid_q;
  logic [63:0] rs1_data_q;
  logic [63:0] rs2_data_q;
  logic [63:0] imm_q;
  logic [4:0]  rs1_addr_q;
  logic [4:0]  rs2_addr_q;
  logic [4:0]  rd_q;
  logic        alu_src_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [3:0]  ctrl_q;

  logic [3:0]  ctrl_next;
  logic        bubble;
  logic [63:0] fwd_a;
  logic [63:0] fwd_b;

  // Decode ALU operation code from alu_op/funct3/instr30; unsupported combinations give 1111.
  always_comb begin
    ctrl_next = 4'b1111;
    case (alu_op_i)
      2'b00: ctrl_next = 4'b0010;
      2'b01: ctrl_next = 4'b0110;
      2'b10: begin
        case (funct3_i)
          3'b000:  ctrl_next = instr30_i ? 4'b0110 : 4'b0010;
          3'b111:  ctrl_next = 4'b0000;
          3'b110:  ctrl_next = 4'b0001;
          3'b010:  ctrl_next = 4'b0111;
          default: ctrl_next = 4'b1111;
        endcase
      end
      default: begin
        // I-type: instr30 is part of the immediate, so it never selects SUB here.
        case (funct3_i)
          3'b000:  ctrl_next = 4'b0010;
          3'b111:  ctrl_next = 4'b0000;
          3'b110:  ctrl_next = 4'b0001;
          3'b010:  ctrl_next = 4'b0111;
          default: ctrl_next = 4'b1111;
        endcase
      end
    endcase
  end

  // Reset, flush and an unstalled invalid load all clear the register to a bubble.
  assign bubble = rst_i || flush_i || (!stall_i && !in_valid_i);

  // Pipeline register: bubble has priority over stall, stall over load.
  always_ff @(posedge clk_i) begin
    if (bubble) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ctrl_q      <= '0;
    end else if (!stall_i) begin
      valid_q     <= 1'b1;
      rs1_data_q  <= rs1_data_i;
      rs2_data_q  <= rs2_data_i;
      imm_q       <= imm_i;
      rs1_addr_q  <= rs1_addr_i;
      rs2_addr_q  <= rs2_addr_i;
      rd_q        <= rd_addr_i;
      alu_src_q   <= alu_src_i;
      reg_write_q <= reg_write_i;
      mem_read_q  <= mem_read_i;
      mem_write_q <= mem_write_i;
      ctrl_q      <= ctrl_next;
    end
  end

  // Operand forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_a = rs1_data_q;
    fwd_b = rs2_data_q;
    if (valid_q) begin
      if (exmem_reg_write_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == rs1_addr_q))
        fwd_a = exmem_result_i;
      else if (memwb_reg_write_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs1_addr_q))
        fwd_a = memwb_result_i;
      if (exmem_reg_write_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == rs2_addr_q))
        fwd_b = exmem_result_i;
      else if (memwb_reg_write_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs2_addr_q))
        fwd_b = memwb_result_i;
    end
  end

  assign src1_o       = fwd_a;
  assign src2_o       = alu_src_q ? imm_q : fwd_b;
  assign store_data_o = fwd_b;
  assign ctrl_o       = ctrl_q;
  assign valid_o      = valid_q;
  assign rd_addr_o    = rd_q;
  assign reg_write_o  = reg_write_q && valid_q;
  assign mem_read_o   = mem_read_q && valid_q;
  assign mem_write_o  = mem_write_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model feeds a scoreboard queue.
// Latency: expected values are pushed before each edge and popped 1 ns after it.
// Backpressure: stall/flush/reset sequences exercised directly.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, in_valid_i;
  logic [63:0] rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [1:0]  alu_op_i;
  logic        alu_src_i;
  logic [2:0]  funct3_i;
  logic        instr30_i, reg_write_i, mem_read_i, mem_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [63:0] exmem_result_i, memwb_result_i;
  logic [63:0] src1_o, src2_o, store_data_o;
  logic [3:0]  ctrl_o;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o;
  logic [4:0]  rd_addr_o;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .alu_op_i(alu_op_i), .alu_src_i(alu_src_i),
    .funct3_i(funct3_i), .instr30_i(instr30_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .exmem_rd_i(exmem_rd_i), .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_result_i(exmem_result_i), .memwb_rd_i(memwb_rd_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_result_i(memwb_result_i),
    .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o), .valid_o(valid_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .rd_addr_o(rd_addr_o), .store_data_o(store_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [63:0] src1, src2, store;
    logic        rw, mr, mw;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  string lbl = "init";

  // Reference model state of the pipeline register
  logic        m_valid, m_alu_src, m_rw, m_mr, m_mw;
  logic [63:0] m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [3:0]  m_ctrl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic i30);
    logic [3:0] r;
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (f3)
      3'b000:  r = (op == 2'b10 && i30) ? 4'b0110 : 4'b0010;
      3'b111:  r = 4'b0000;
      3'b110:  r = 4'b0001;
      3'b010:  r = 4'b0111;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ref_fwd(input logic [4:0] a, input logic [63:0] regval);
    if (!m_valid) return regval;
    if (exmem_reg_write_i && exmem_rd_i != 0 && exmem_rd_i == a) return exmem_result_i;
    if (memwb_reg_write_i && memwb_rd_i != 0 && memwb_rd_i == a) return memwb_result_i;
    return regval;
  endfunction

  // Advance the model for the coming edge, push expectation, clock, pop and compare.
  task automatic step();
    exp_t e;
    if (rst_i || flush_i || (!stall_i && !in_valid_i)) begin
      m_valid = 0; m_alu_src = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_ctrl = 0;
    end else if (!stall_i) begin
      m_valid = 1; m_alu_src = alu_src_i; m_rw = reg_write_i; m_mr = mem_read_i;
      m_mw = mem_write_i; m_rs1d = rs1_data_i; m_rs2d = rs2_data_i; m_imm = imm_i;
      m_rs1a = rs1_addr_i; m_rs2a = rs2_addr_i; m_rd = rd_addr_i;
      m_ctrl = ref_ctrl(alu_op_i, funct3_i, instr30_i);
    end
    e.valid = m_valid;
    e.ctrl  = m_ctrl;
    e.rd    = m_rd;
    e.src1  = ref_fwd(m_rs1a, m_rs1d);
    e.store = ref_fwd(m_rs2a, m_rs2d);
    e.src2  = m_alu_src ? m_imm : e.store;
    e.rw    = m_rw & m_valid;
    e.mr    = m_mr & m_valid;
    e.mw    = m_mw & m_valid;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check({lbl, ".valid"}, 64'(valid_o),     64'(e.valid));
    check({lbl, ".ctrl"},  64'(ctrl_o),      64'(e.ctrl));
    check({lbl, ".rd"},    64'(rd_addr_o),   64'(e.rd));
    check({lbl, ".src1"},  src1_o,           e.src1);
    check({lbl, ".src2"},  src2_o,           e.src2);
    check({lbl, ".store"}, store_data_o,     e.store);
    check({lbl, ".rw"},    64'(reg_write_o), 64'(e.rw));
    check({lbl, ".mr"},    64'(mem_read_o),  64'(e.mr));
    check({lbl, ".mw"},    64'(mem_write_o), 64'(e.mw));
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic i30,
                           input logic asrc, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                           input logic [63:0] imm, input logic rw, input logic mr, input logic mw);
    in_valid_i = 1; alu_op_i = op; funct3_i = f3; instr30_i = i30; alu_src_i = asrc;
    rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = rd; rs1_data_i = d1; rs2_data_i = d2;
    imm_i = imm; reg_write_i = rw; mem_read_i = mr; mem_write_i = mw;
  endtask

  task automatic no_fwd();
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_result_i = 64'hDEAD;
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_result_i = 64'hBEEF;
  endtask

  initial begin
    rst_i = 1; stall_i = 1; flush_i = 0;
    set_instr(2'b10, 3'b000, 0, 0, 5'd1, 5'd2, 5'd3, 64'h55, 64'h66, 64'h77, 1, 1, 1);
    no_fwd();
    // Initialise model to don't-care-free values; first step resets it.
    m_valid = 0; m_alu_src = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_ctrl = 0;

    lbl = "reset"; step(); step();
    rst_i = 0; stall_i = 0;

    lbl = "sub";
    set_instr(2'b10, 3'b000, 1, 0, 5'd1, 5'd2, 5'd3, 64'd5, 64'd3, 64'd0, 1, 0, 0);
    step();

    lbl = "addi";
    set_instr(2'b11, 3'b000, 1, 1, 5'd4, 5'd0, 5'd6, 64'd10, 64'd99, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0);
    step();

    // Full decode sweep with random operand data
    for (int op = 0; op < 4; op++)
      for (int f = 0; f < 8; f++)
        for (int b = 0; b < 2; b++) begin
          lbl = $sformatf("dec_op%0d_f%0d_b%0d", op, f, b);
          set_instr(2'(op), 3'(f), 1'(b), 1'($urandom_range(0, 1)), 5'($urandom),
                    5'($urandom), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
          step();
        end

    // Double hazard on rs1 and rs2 (both x7)
    lbl = "haz_both";
    set_instr(2'b10, 3'b000, 0, 0, 5'd7, 5'd7, 5'd8, 64'h11, 64'h22, 64'h0, 1, 0, 0);
    exmem_reg_write_i = 1; exmem_rd_i = 5'd7; exmem_result_i = 64'hAA;
    memwb_reg_write_i = 1; memwb_rd_i = 5'd7; memwb_result_i = 64'hBB;
    step();
    lbl = "haz_memwb"; stall_i = 1; exmem_rd_i = 5'd0; step();
    lbl = "haz_none";  exmem_reg_write_i = 0; memwb_reg_write_i = 0; step();
    lbl = "haz_exrw0"; exmem_rd_i = 5'd7; memwb_reg_write_i = 1; step();
    stall_i = 0;
    lbl = "haz_x0";
    set_instr(2'b10, 3'b110, 0, 0, 5'd0, 5'd0, 5'd9, 64'h33, 64'h44, 64'h0, 1, 0, 0);
    exmem_reg_write_i = 1; exmem_rd_i = 5'd0; memwb_reg_write_i = 1; memwb_rd_i = 5'd0;
    step();
    lbl = "haz_immsrc";
    set_instr(2'b00, 3'b011, 0, 1, 5'd12, 5'd13, 5'd0, 64'h1000, 64'h2000, 64'h18, 0, 0, 1);
    exmem_rd_i = 5'd13; exmem_result_i = 64'hCAFE; memwb_rd_i = 5'd12; memwb_result_i = 64'hF00D;
    step();
    no_fwd();

    // Store, then hold for three cycles while decode inputs churn, then stall+flush
    lbl = "sw";
    set_instr(2'b00, 3'b010, 0, 1, 5'd2, 5'd5, 5'd0, 64'h100, 64'h1234, 64'h8, 0, 0, 1);
    step();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      lbl = $sformatf("stall%0d", i);
      set_instr(2'b10, 3'($urandom), 1, 0, 5'($urandom), 5'($urandom), 5'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, 0);
      in_valid_i = 1'(i & 1);
      step();
    end
    lbl = "stall_flush"; flush_i = 1; step();
    stall_i = 0; flush_i = 0;

    lbl = "unsup";
    set_instr(2'b10, 3'b001, 0, 0, 5'd1, 5'd2, 5'd3, 64'd7, 64'd8, 64'd0, 1, 0, 0);
    step();
    lbl = "inval";
    set_instr(2'b10, 3'b000, 0, 0, 5'd1, 5'd2, 5'd3, 64'd7, 64'd8, 64'd9, 1, 1, 1);
    in_valid_i = 0;
    step();

    // Reset during stall clears held contents; first edge after release loads
    lbl = "pre_rst";
    set_instr(2'b10, 3'b111, 0, 0, 5'd3, 5'd4, 5'd5, 64'hAB, 64'hCD, 64'h0, 1, 1, 0);
    step();
    lbl = "rst_stall"; rst_i = 1; stall_i = 1; step();
    lbl = "post_rst"; rst_i = 0; stall_i = 0;
    set_instr(2'b01, 3'b000, 0, 0, 5'd6, 5'd7, 5'd8, 64'd20, 64'd6, 64'd0, 0, 0, 0);
    step();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
